morse_symbol_assembler: RTL and testbench



---
 rtl/morse_pkg.sv | 43 ++++
 rtl/morse_code_fifo.sv | 72 +++++++
 rtl/morse_symbol_assembler.sv | 164 ++++++++++++++++
 tb/tb_morse_symbol_assembler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : morse_pkg
//  Description : Shared element encoding and code-word helpers for the Morse
//                symbol assembly path. Code words are {length, pattern}.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package morse_pkg;

    // Element encoding inside a pattern (LSB = newest element)
    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    // Widest code word the helpers can describe (MAX_LEN=7 needs 11 bits)
    localparam int c_code_max_w = 16;

    // Length field must hold 0..MAX_LEN plus an all-ones marker value
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 2);
    endfunction

    // SPACE: length field all ones, pattern all zeros
    function automatic logic [c_code_max_w-1:0] space_code(input int max_len);
        logic [c_code_max_w-1:0] v;
        v = '0;
        for (int i = 0; i < len_w(max_len); i++) begin
            v[max_len + i] = 1'b1;
        end
        return v;
    endfunction

    // ERROR: every bit of the code word set
    function automatic logic [c_code_max_w-1:0] error_code(input int max_len);
        logic [c_code_max_w-1:0] v;
        v = '0;
        for (int i = 0; i < max_len + len_w(max_len); i++) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/morse_code_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : morse_code_fifo
//  Description : Synchronous first-word-fall-through FIFO. Head is presented
//                combinationally from storage; writes when full are refused
//                unless a read happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_code_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic               w_wr;
    logic               w_rd;

    assign empty = (r_level == '0);
    assign full  = (r_level == c_lvl_w'(DEPTH));
    assign level = r_level;
    assign dout  = r_mem[r_rd_ptr];

    // A read needs data; a write needs room or a simultaneous read
    assign w_rd = rd_en & ~empty;
    assign w_wr = wr_en & (~full | w_rd);

    // Storage array: no reset, contents are only observed while non-empty
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy move together; power-of-two depth wraps freely
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/morse_symbol_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : morse_symbol_assembler
//  Description : Accumulates dot/dash pulses into {length, pattern} letter
//                codes, closes letters on letter/word gaps, inserts SPACE and
//                ERROR codes, and queues results in a FWFT FIFO with a
//                saturating drop counter.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module morse_symbol_assembler
    import morse_pkg::*;
#(
    parameter int MAX_LEN         = 5,
    parameter int DEPTH           = 16,
    parameter bit COLLAPSE_SPACES = 1'b1,
    parameter int LEN_W           = len_w(MAX_LEN),
    parameter int CODE_W          = LEN_W + MAX_LEN
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dot,
    input  logic                       dash,
    input  logic                       lg,
    input  logic                       wg,
    output logic [CODE_W-1:0]          out_code,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LEN_W-1:0]           cur_len,
    output logic [MAX_LEN-1:0]         cur_pattern,
    output logic                       overlong,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [7:0]                 drop_count
);

    localparam logic [CODE_W-1:0] c_space   = CODE_W'(space_code(MAX_LEN));
    localparam logic [CODE_W-1:0] c_error   = CODE_W'(error_code(MAX_LEN));
    localparam logic [LEN_W-1:0]  c_max_len = LEN_W'(MAX_LEN);

    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-1:0] r_pattern;
    logic               r_overlong;
    logic               r_space_pending;
    logic               r_last_was_space;
    logic [7:0]         r_drop_count;

    logic               w_elem;
    logic               w_elem_bit;
    logic [MAX_LEN-1:0] w_shifted;
    logic               w_close;
    logic               w_gap_ignored;
    logic               w_push;
    logic               w_letter_push;
    logic               w_space_push;
    logic [CODE_W-1:0]  w_push_data;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_overflow;
    logic [8:0]         w_drop_sum;

    // dot and dash together cancel out
    assign w_elem     = dot ^ dash;
    assign w_elem_bit = dash ? DASH : DOT;

    // A deferred SPACE owns this cycle; gap pulses arriving now are lost
    assign w_gap_ignored = r_space_pending & (lg | wg);
    assign w_close       = ~r_space_pending & (lg | wg) & (r_len != '0);

    // Shift the newest element in at the LSB
    generate
        if (MAX_LEN > 1) begin : g_shift_wide
            assign w_shifted = {r_pattern[MAX_LEN-2:0], w_elem_bit};
        end else begin : g_shift_single
            assign w_shifted = w_elem_bit;
        end
    endgenerate

    // Select at most one push source per cycle
    always_comb begin
        w_push        = 1'b0;
        w_letter_push = 1'b0;
        w_space_push  = 1'b0;
        w_push_data   = c_space;
        if (r_space_pending) begin
            w_push       = 1'b1;
            w_space_push = 1'b1;
        end else if (w_close) begin
            w_push        = 1'b1;
            w_letter_push = 1'b1;
            w_push_data   = r_overlong ? c_error : {r_len, r_pattern};
        end else if (wg && !(COLLAPSE_SPACES && r_last_was_space)) begin
            w_push       = 1'b1;
            w_space_push = 1'b1;
        end
    end

    assign out_valid  = ~w_empty;
    assign w_pop      = out_valid & out_ready;
    assign w_overflow = w_push & w_full & ~w_pop;
    assign w_drop_sum = {1'b0, r_drop_count} + 9'(w_overflow) + 9'(w_gap_ignored);

    // Letter accumulation, space deferral and drop accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len            <= '0;
            r_pattern        <= '0;
            r_overlong       <= 1'b0;
            r_space_pending  <= 1'b0;
            r_last_was_space <= 1'b0;
            r_drop_count     <= '0;
        end else begin
            if (w_close) begin
                // Closure consumed the old letter; a coincident element opens the next
                r_overlong <= 1'b0;
                if (w_elem) begin
                    r_len     <= LEN_W'(1);
                    r_pattern <= MAX_LEN'(w_elem_bit);
                end else begin
                    r_len     <= '0;
                    r_pattern <= '0;
                end
            end else if (w_elem) begin
                if (r_len < c_max_len) begin
                    r_len     <= r_len + LEN_W'(1);
                    r_pattern <= w_shifted;
                end else begin
                    r_overlong <= 1'b1;
                end
            end

            r_space_pending <= w_close & wg;

            if (w_letter_push) begin
                r_last_was_space <= 1'b0;
            end else if (w_space_push) begin
                r_last_was_space <= 1'b1;
            end

            r_drop_count <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    morse_code_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (w_push),
        .din   (w_push_data),
        .rd_en (w_pop),
        .dout  (out_code),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    assign cur_len     = r_len;
    assign cur_pattern = r_pattern;
    assign overlong    = r_overlong;
    assign drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_morse_symbol_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_symbol_assembler
//  Description : Directed bench. Instance A: DEPTH=4, collapsing spaces.
//                Instance B: DEPTH=16, non-collapsing. Both share stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_symbol_assembler;

    logic       clk = 1'b0;
    logic       reset, dot, dash, lg, wg, out_ready;

    logic [7:0] a_code, b_code;
    logic       a_valid, b_valid;
    logic [2:0] a_len, b_len;
    logic [4:0] a_pat, b_pat;
    logic       a_ovl, b_ovl;
    logic [2:0] a_level;
    logic [4:0] b_level;
    logic [7:0] a_drop, b_drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    morse_symbol_assembler #(
        .MAX_LEN(5), .DEPTH(4), .COLLAPSE_SPACES(1'b1)
    ) u_dut_a (
        .clk(clk), .reset(reset), .dot(dot), .dash(dash), .lg(lg), .wg(wg),
        .out_code(a_code), .out_valid(a_valid), .out_ready(out_ready),
        .cur_len(a_len), .cur_pattern(a_pat), .overlong(a_ovl),
        .level(a_level), .drop_count(a_drop)
    );

    morse_symbol_assembler #(
        .MAX_LEN(5), .DEPTH(16), .COLLAPSE_SPACES(1'b0)
    ) u_dut_b (
        .clk(clk), .reset(reset), .dot(dot), .dash(dash), .lg(lg), .wg(wg),
        .out_code(b_code), .out_valid(b_valid), .out_ready(out_ready),
        .cur_len(b_len), .cur_pattern(b_pat), .overlong(b_ovl),
        .level(b_level), .drop_count(b_drop)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic d, input logic s, input logic l, input logic w);
        dot = d; dash = s; lg = l; wg = w;
        step();
        dot = 1'b0; dash = 1'b0; lg = 1'b0; wg = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; dot = 1'b0; dash = 1'b0; lg = 1'b0; wg = 1'b0; out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_len",   32'(a_len),   32'd0);
        chk("rst_pat",   32'(a_pat),   32'd0);
        chk("rst_ovl",   32'(a_ovl),   32'd0);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_level", 32'(a_level), 32'd0);
        chk("rst_drop",  32'(a_drop),  32'd0);
        chk("rst_b_len", 32'(b_len),   32'd0);
        chk("rst_b_pat", 32'(b_pat),   32'd0);
        chk("rst_b_ovl", 32'(b_ovl),   32'd0);
        chk("rst_b_vld", 32'(b_valid), 32'd0);

        // dot, dash, lg -> {2, 00001}
        pulse(1, 0, 0, 0); step();
        pulse(0, 1, 0, 0); step();
        chk("t1_len", 32'(a_len), 32'd2);
        chk("t1_pat", 32'(a_pat), 32'h01);
        pulse(0, 0, 1, 0);
        chk("t1_valid",  32'(a_valid), 32'd1);
        chk("t1_code",   32'(a_code),  32'h41);
        chk("t1_len0",   32'(a_len),   32'd0);
        chk("t1_b_code", 32'(b_code),  32'h41);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t1_popped", 32'(a_valid), 32'd0);
        chk("t1_lvl0",   32'(a_level), 32'd0);

        // Six dashes overflow MAX_LEN=5
        for (int i = 0; i < 5; i++) begin
            pulse(0, 1, 0, 0); step();
        end
        chk("t2_len5", 32'(a_len), 32'd5);
        chk("t2_pat",  32'(a_pat), 32'h1F);
        chk("t2_ovl0", 32'(a_ovl), 32'd0);
        pulse(0, 1, 0, 0);
        chk("t2_ovl1",    32'(a_ovl), 32'd1);
        chk("t2_lenhold", 32'(a_len), 32'd5);
        pulse(0, 0, 1, 0);
        chk("t2_err",   32'(a_code), 32'hFF);
        chk("t2_len0",  32'(a_len),  32'd0);
        chk("t2_ovlc",  32'(a_ovl),  32'd0);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // dot then wg: letter now, SPACE one cycle later
        pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        chk("t3_lvl1",   32'(a_level), 32'd1);
        chk("t3_letter", 32'(a_code),  32'h20);
        step();
        chk("t3_lvl2",   32'(a_level), 32'd2);
        chk("t3_b_lvl2", 32'(b_level), 32'd2);
        out_ready = 1'b1; step();
        chk("t3_space",  32'(a_code),  32'hE0);
        step(); out_ready = 1'b0;
        chk("t3_drain",  32'(a_level), 32'd0);

        // Three bare word gaps: A collapses to one SPACE, B queues three
        do_reset();
        pulse(0, 0, 0, 1); pulse(0, 0, 0, 1); pulse(0, 0, 0, 1);
        chk("t4_a_lvl",  32'(a_level), 32'd1);
        chk("t4_a_code", 32'(a_code),  32'hE0);
        chk("t4_b_lvl",  32'(b_level), 32'd3);

        // Six letters into a 4-deep FIFO
        do_reset();
        pulse(1, 0, 0, 0); pulse(0, 0, 1, 0);
        pulse(0, 1, 0, 0); pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0); pulse(1, 0, 0, 0); pulse(0, 0, 1, 0);
        pulse(0, 1, 0, 0); pulse(0, 1, 0, 0); pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0); pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0); pulse(0, 0, 1, 0);
        chk("t5_a_lvl",  32'(a_level), 32'd4);
        chk("t5_a_drop", 32'(a_drop),  32'd2);
        chk("t5_b_lvl",  32'(b_level), 32'd6);
        chk("t5_b_drop", 32'(b_drop),  32'd0);
        out_ready = 1'b1;
        chk("t5_q0", 32'(a_code), 32'h20); step();
        chk("t5_q1", 32'(a_code), 32'h21); step();
        chk("t5_q2", 32'(a_code), 32'h40); step();
        chk("t5_q3", 32'(a_code), 32'h43); step();
        out_ready = 1'b0;
        chk("t5_empty", 32'(a_valid), 32'd0);
        chk("t5_lvl0",  32'(a_level), 32'd0);

        // Element coincident with closure starts the next letter
        do_reset();
        pulse(1, 0, 0, 0);
        pulse(0, 1, 1, 0);
        chk("t6_code", 32'(a_code), 32'h20);
        chk("t6_len",  32'(a_len),  32'd1);
        chk("t6_pat",  32'(a_pat),  32'h01);
        pulse(1, 1, 0, 0);
        chk("t6_both_ignored", 32'(a_len), 32'd1);

        // Gap during the deferred SPACE cycle is dropped
        do_reset();
        pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        pulse(0, 0, 1, 0);
        chk("t7_lvl2",   32'(a_level), 32'd2);
        chk("t7_a_drop", 32'(a_drop),  32'd1);
        chk("t7_b_drop", 32'(b_drop),  32'd1);
        pulse(0, 0, 0, 1);
        chk("t7_a_collapse", 32'(a_level), 32'd2);
        chk("t7_b_extra",    32'(b_level), 32'd3);

        // Reset mid-letter discards the letter
        do_reset();
        pulse(1, 0, 0, 0); pulse(1, 0, 0, 0); pulse(1, 0, 0, 0);
        chk("t8_len3", 32'(a_len), 32'd3);
        do_reset();
        chk("t8_len0", 32'(a_len), 32'd0);
        chk("t8_pat0", 32'(a_pat), 32'd0);
        pulse(0, 0, 1, 0); step();
        chk("t8_nopush", 32'(a_level), 32'd0);
        chk("t8_novld",  32'(a_valid), 32'd0);

        // Reset while a SPACE is pending discards it
        pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        do_reset();
        chk("t9_lvl0",  32'(a_level), 32'd0);
        chk("t9_drop0", 32'(a_drop),  32'd0);
        step();
        chk("t9_nospace", 32'(a_level), 32'd0);
        chk("t9_b_nospace", 32'(b_level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
